sub4_serial: RTL and testbench

SUB4_SERIAL -- requirements
Module: sub4_serial

---
 rtl/sub_pkg.sv | 13 +
 rtl/full_subtractor.sv | 16 +
 rtl/sub4_serial.sv | 131 +++++++++++++
 tb/tb_sub4_serial.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sub_pkg.sv
// Shared definitions for the serial subtractor: FSM state encoding and
// the default operand width.
package sub_pkg;

    localparam int WIDTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, with borrow-out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Difference bit and borrow generation for a single bit position.
    always_comb begin
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~a & bin) | (b & bin);
    end

endmodule

// File: rtl/sub4_serial.sv
// Bit-serial subtractor: computes (A - B - Bin) one bit per cycle, LSB first,
// behind a valid/ready handshake on both the operand and result sides.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for operands; io_inReady high
// BUSY  | shifting one bit per cycle through the full subtractor
// DONE  | result presented; io_outValid high until consumer takes it
module sub4_serial
    import sub_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] io_A,
    input  logic [WIDTH-1:0] io_B,
    input  logic             io_Bin,
    input  logic             io_inValid,
    output logic             io_inReady,
    output logic [WIDTH-1:0] io_Diff,
    output logic             io_Bout,
    output logic             io_outValid,
    input  logic             io_outReady
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-2:0] res_sr;
    logic [WIDTH-1:0] res_next;
    logic [WIDTH-1:0] diff_q;
    logic             br_q;
    logic             bout_q;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             shift_en;
    logic             last_bit;
    logic             fs_d;
    logic             fs_bout;

    full_subtractor u_fs (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (br_q),
        .d    (fs_d),
        .bout (fs_bout)
    );

    // Partial result with the bit produced this cycle placed at the MSB.
    assign res_next = {fs_d, res_sr};

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, handshake outputs and datapath enables.
    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        shift_en    = 1'b0;
        last_bit    = 1'b0;
        io_inReady  = 1'b0;
        io_outValid = 1'b0;
        case (state)
            IDLE: begin
                io_inReady = 1'b1;
                if (io_inValid) begin
                    accept    = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                shift_en = 1'b1;
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    last_bit  = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                io_outValid = 1'b1;
                if (io_outReady) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, bit-serial shifting, and result publication. The
    // visible result only changes on the final bit so it stays at the last
    // completed value while a new operation is in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            a_sr   <= '0;
            b_sr   <= '0;
            br_q   <= 1'b0;
            res_sr <= '0;
            cnt    <= '0;
            diff_q <= '0;
            bout_q <= 1'b0;
        end else if (accept) begin
            a_sr <= io_A;
            b_sr <= io_B;
            br_q <= io_Bin;
            cnt  <= '0;
        end else if (shift_en) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            br_q   <= fs_bout;
            res_sr <= res_next[WIDTH-1:1];
            cnt    <= cnt + CNT_W'(1);
            if (last_bit) begin
                diff_q <= res_next;
                bout_q <= fs_bout;
            end
        end
    end

    assign io_Diff = diff_q;
    assign io_Bout = bout_q;

endmodule

// File: tb/tb_sub4_serial.sv
// Testbench for sub4_serial: directed vector table, multi-cycle corner cases,
// and an exhaustive 4-bit sweep, with a scoreboard checking every result.
module tb_sub4_serial;

    localparam int W = 4;

    logic         clock;
    logic         reset;
    logic [W-1:0] io_A;
    logic [W-1:0] io_B;
    logic         io_Bin;
    logic         io_inValid;
    logic         io_inReady;
    logic [W-1:0] io_Diff;
    logic         io_Bout;
    logic         io_outValid;
    logic         io_outReady;

    typedef struct {
        logic [W-1:0] diff;
        logic         bout;
    } exp_t;

    typedef struct {
        int a;
        int b;
        int bin;
        int diff;
        int bout;
    } vec_t;

    exp_t exp_q[$];
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   n_pushed  = 0;
    int   n_drained = 0;

    sub4_serial #(.WIDTH(W)) dut (
        .clock       (clock),
        .reset       (reset),
        .io_A        (io_A),
        .io_B        (io_B),
        .io_Bin      (io_Bin),
        .io_inValid  (io_inValid),
        .io_inReady  (io_inReady),
        .io_Diff     (io_Diff),
        .io_Bout     (io_Bout),
        .io_outValid (io_outValid),
        .io_outReady (io_outReady)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic bin);
        logic [W:0] t;
        exp_t       e;
        t      = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
        e.diff = t[W-1:0];
        e.bout = t[W];
        return e;
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Scoreboard: push the model result when an operand handshake is about
    // to complete, pop and compare when a result handshake is about to.
    always @(negedge clock) begin
        if (reset) begin
            if (io_inValid && io_inReady) begin
                exp_q.push_back(model(io_A, io_B, io_Bin));
                n_pushed++;
            end
            if (io_outValid && io_outReady) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_underflow: got result %0d with no expected entry", io_Diff);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("sb_diff", int'(io_Diff), int'(e.diff));
                    check("sb_bout", int'(io_Bout), int'(e.bout));
                    n_drained++;
                end
            end
        end
    end

    // Present operands and wait (bounded) for the accepting edge.
    task automatic send(input int a, input int b, input int bin);
        int n;
        io_A       = W'(a);
        io_B       = W'(b);
        io_Bin     = 1'(bin);
        io_inValid = 1'b1;
        n = 0;
        while (!io_inReady && n < 50) begin
            tick();
            n++;
        end
        check("in_ready_timeout", int'(n < 50), 1);
        tick();
        io_inValid = 1'b0;
        check("accepted_in_ready_low", int'(io_inReady), 0);
    endtask

    // Count edges from the accepting edge until io_outValid rises.
    task automatic wait_out(output int lat);
        lat = 0;
        while (!io_outValid && lat < 50) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        vec_t vecs[7];
        int   lat;

        vecs[0] = '{9,  3,  0, 6,  0};
        vecs[1] = '{3,  9,  0, 10, 1};
        vecs[2] = '{0,  0,  1, 15, 1};
        vecs[3] = '{15, 15, 1, 15, 1};
        vecs[4] = '{15, 0,  0, 15, 0};
        vecs[5] = '{0,  15, 1, 0,  1};
        vecs[6] = '{8,  1,  1, 6,  0};

        reset       = 1'b0;
        io_A        = '0;
        io_B        = '0;
        io_Bin      = 1'b0;
        io_inValid  = 1'b0;
        io_outReady = 1'b0;

        #12;
        check("rst_in_ready",  int'(io_inReady),  1);
        check("rst_out_valid", int'(io_outValid), 0);
        check("rst_diff",      int'(io_Diff),     0);
        check("rst_bout",      int'(io_Bout),     0);

        // Release reset just after an edge; the first vector is presented at
        // the same time so it must be taken on the very next rising edge.
        tick();
        reset = 1'b1;

        foreach (vecs[i]) begin
            send(vecs[i].a, vecs[i].b, vecs[i].bin);
            wait_out(lat);
            check($sformatf("latency_%0d", i), lat, W);
            check($sformatf("diff_%0d", i), int'(io_Diff), vecs[i].diff);
            check($sformatf("bout_%0d", i), int'(io_Bout), vecs[i].bout);
            io_outReady = 1'b1;
            tick();
            io_outReady = 1'b0;
            check($sformatf("drained_valid_%0d", i), int'(io_outValid), 0);
            check($sformatf("drained_ready_%0d", i), int'(io_inReady), 1);
        end

        // Result held under back-pressure; operands offered meanwhile are ignored.
        send(5, 1, 0);
        wait_out(lat);
        io_A       = 4'd2;
        io_B       = 4'd1;
        io_Bin     = 1'b0;
        io_inValid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_valid",    int'(io_outValid), 1);
            check("stall_diff",     int'(io_Diff),     4);
            check("stall_bout",     int'(io_Bout),     0);
            check("stall_in_ready", int'(io_inReady),  0);
        end
        io_inValid  = 1'b0;
        io_outReady = 1'b1;
        tick();
        io_outReady = 1'b0;
        check("stall_drained", int'(io_outValid), 0);

        // Reset in the second BUSY cycle aborts the operation.
        send(12, 5, 0);
        tick();
        reset = 1'b0;
        #1;
        exp_q.delete();
        check("abort_out_valid", int'(io_outValid), 0);
        check("abort_in_ready",  int'(io_inReady),  1);
        check("abort_diff",      int'(io_Diff),     0);
        check("abort_bout",      int'(io_Bout),     0);
        tick();
        tick();
        reset = 1'b1;
        check("abort_no_result", int'(io_outValid), 0);
        send(7, 2, 0);
        wait_out(lat);
        check("post_abort_latency", lat, W);
        check("post_abort_diff", int'(io_Diff), 5);
        check("post_abort_bout", int'(io_Bout), 0);
        io_outReady = 1'b1;
        tick();
        io_outReady = 1'b0;

        // Exhaustive sweep with random consumer stalls, checked by the scoreboard.
        n_pushed  = 0;
        n_drained = 0;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int bin = 0; bin < 2; bin++) begin
                    send(a, b, bin);
                    wait_out(lat);
                    if (lat >= 50) check("sweep_out_timeout", lat, W);
                    repeat ($urandom_range(0, 3)) tick();
                    io_outReady = 1'b1;
                    tick();
                    io_outReady = 1'b0;
                end
            end
        end
        tick();
        check("sweep_pushed",  n_pushed,  512);
        check("sweep_drained", n_drained, 512);
        check("sweep_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
